// File: rtl/vend_pkg.sv
// Shared encodings for the vending sequencer: FSM states, coin codes and coin values in 5c units.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CREDIT   = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;

  localparam int UNIT_5  = 1;
  localparam int UNIT_10 = 2;

  // Value of a coin code in credit units; none and bad codes are worth nothing.
  function automatic logic [1:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_NONE: return 2'd0;
      COIN_5:    return 2'(UNIT_5);
      COIN_10:   return 2'(UNIT_10);
      COIN_BAD:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_credit_acc.sv
// Credit register in 5c units with coin decode, MAX_CREDIT fit check, add/subtract/clear; 1-cycle update.
// No backpressure: the sequencer only asserts add_en for a coin that coin_fits has approved.
module vend_credit_acc
  import vend_pkg::*;
#(
  parameter int CREDIT_W   = 5,
  parameter int MAX_CREDIT = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic                add_en,
  input  logic                sub_en,
  input  logic [CREDIT_W-1:0] sub_amt,
  input  logic                clr,
  output logic                coin_fits,
  output logic [CREDIT_W-1:0] credit
);

  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [1:0]          coin_val;
  logic [CREDIT_W:0]   sum;

  // One extra sum bit so the MAX_CREDIT compare cannot be fooled by wrap-around.
  always_comb begin
    coin_val  = coin_value(coin);
    sum       = (CREDIT_W+1)'(credit_q) + (CREDIT_W+1)'(coin_val);
    coin_fits = (coin_val != 2'd0) && (sum <= (CREDIT_W+1)'(MAX_CREDIT));
    credit_d  = credit_q;
    if (clr) begin
      credit_d = '0;
    end else if (sub_en) begin
      credit_d = credit_q - sub_amt;
    end else if (add_en) begin
      credit_d = sum[CREDIT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_q <= '0;
    end else begin
      credit_q <= credit_d;
    end
  end

  assign credit = credit_q;

endmodule

// File: rtl/vend_seq_ctrl.sv
// Vending transaction sequencer: coin credit, price check, dispense and change req/ack handshakes.
// All outputs registered; sel_vld->disp_req and disp_ack->chg_req take 1 cycle, each req holds until its ack.
module vend_seq_ctrl
  import vend_pkg::*;
#(
  parameter int CREDIT_W   = 5,
  parameter int MAX_CREDIT = 20,
  parameter int PRICE0     = 3,
  parameter int PRICE1     = 4,
  parameter int PRICE2     = 5,
  parameter int PRICE3     = 7,
  parameter int TIMEOUT    = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_vld,
  input  logic [1:0]          coin,
  input  logic                sel_vld,
  input  logic [1:0]          sel,
  input  logic                cancel,
  output logic                disp_req,
  output logic [1:0]          disp_id,
  input  logic                disp_ack,
  output logic                chg_req,
  output logic [CREDIT_W-1:0] chg_amt,
  input  logic                chg_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_rej,
  output logic                low_credit,
  output logic                vend_done,
  output logic                busy
);

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                disp_req_q, disp_req_d;
  logic [1:0]          disp_id_q, disp_id_d;
  logic                chg_req_q, chg_req_d;
  logic [CREDIT_W-1:0] chg_amt_q, chg_amt_d;
  logic                coin_rej_q, coin_rej_d;
  logic                low_credit_q, low_credit_d;
  logic                vend_done_q, vend_done_d;
  logic                busy_q, busy_d;
  logic                acc_add, acc_sub, acc_clr, coin_fits;
  logic [CREDIT_W-1:0] credit_now, price;

  vend_credit_acc #(
    .CREDIT_W   (CREDIT_W),
    .MAX_CREDIT (MAX_CREDIT)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .coin      (coin),
    .add_en    (acc_add),
    .sub_en    (acc_sub),
    .sub_amt   (price),
    .clr       (acc_clr),
    .coin_fits (coin_fits),
    .credit    (credit_now)
  );

  always_comb begin
    case (sel)
      2'd0: price = CREDIT_W'(PRICE0);
      2'd1: price = CREDIT_W'(PRICE1);
      2'd2: price = CREDIT_W'(PRICE2);
      2'd3: price = CREDIT_W'(PRICE3);
    endcase
  end

  // Any coin not explicitly accepted below is rejected, including coins dropped by priority.
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    disp_req_d   = disp_req_q;
    disp_id_d    = disp_id_q;
    chg_req_d    = chg_req_q;
    chg_amt_d    = chg_amt_q;
    coin_rej_d   = coin_vld;
    low_credit_d = 1'b0;
    vend_done_d  = 1'b0;
    acc_add      = 1'b0;
    acc_sub      = 1'b0;
    acc_clr      = 1'b0;

    case (state_q)
      IDLE: begin
        low_credit_d = sel_vld;
        if (coin_vld && coin_fits) begin
          acc_add    = 1'b1;
          coin_rej_d = 1'b0;
          state_d    = CREDIT;
        end
      end
      CREDIT: begin
        cnt_d = cnt_q;
        if (cancel) begin
          state_d   = CHANGE;
          chg_req_d = 1'b1;
          chg_amt_d = credit_now;
        end else if (sel_vld) begin
          if (credit_now >= price) begin
            acc_sub    = 1'b1;
            disp_id_d  = sel;
            disp_req_d = 1'b1;
            state_d    = DISPENSE;
          end else begin
            low_credit_d = 1'b1;
          end
        end else if (coin_vld && coin_fits) begin
          acc_add    = 1'b1;
          coin_rej_d = 1'b0;
          cnt_d      = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = CHANGE;
          chg_req_d = 1'b1;
          chg_amt_d = credit_now;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DISPENSE: begin
        if (disp_ack) begin
          disp_req_d  = 1'b0;
          vend_done_d = 1'b1;
          if (credit_now != '0) begin
            state_d   = CHANGE;
            chg_req_d = 1'b1;
            chg_amt_d = credit_now;
          end else begin
            state_d = IDLE;
          end
        end
      end
      CHANGE: begin
        if (chg_ack) begin
          chg_req_d = 1'b0;
          chg_amt_d = '0;
          acc_clr   = 1'b1;
          state_d   = IDLE;
        end
      end
    endcase

    busy_d = (state_d == DISPENSE) || (state_d == CHANGE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      disp_req_q   <= 1'b0;
      disp_id_q    <= 2'd0;
      chg_req_q    <= 1'b0;
      chg_amt_q    <= '0;
      coin_rej_q   <= 1'b0;
      low_credit_q <= 1'b0;
      vend_done_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      disp_req_q   <= disp_req_d;
      disp_id_q    <= disp_id_d;
      chg_req_q    <= chg_req_d;
      chg_amt_q    <= chg_amt_d;
      coin_rej_q   <= coin_rej_d;
      low_credit_q <= low_credit_d;
      vend_done_q  <= vend_done_d;
      busy_q       <= busy_d;
    end
  end

  assign disp_req   = disp_req_q;
  assign disp_id    = disp_id_q;
  assign chg_req    = chg_req_q;
  assign chg_amt    = chg_amt_q;
  assign credit     = credit_now;
  assign coin_rej   = coin_rej_q;
  assign low_credit = low_credit_q;
  assign vend_done  = vend_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_vend_seq_ctrl.sv
// Scoreboard bench for vend_seq_ctrl: directed and random stimulus against a phase-level model
// that predicts every change of the output vector together with the cycle it should appear in.
module tb_vend_seq_ctrl;

  localparam int CW     = 5;
  localparam int MAXC   = 20;
  localparam int TMO    = 8;
  localparam int P_IDLE = 0;
  localparam int P_CRED = 1;
  localparam int P_DISP = 2;
  localparam int P_CHG  = 3;

  typedef struct packed {
    logic          disp_req;
    logic [1:0]    disp_id;
    logic          chg_req;
    logic [CW-1:0] chg_amt;
    logic [CW-1:0] credit;
    logic          coin_rej;
    logic          low_credit;
    logic          vend_done;
    logic          busy;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          coin_vld, sel_vld, cancel, disp_ack, chg_ack;
  logic [1:0]    coin, sel, disp_id;
  logic          disp_req, chg_req, coin_rej, low_credit, vend_done, busy;
  logic [CW-1:0] chg_amt, credit;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t expq[$];
  int   price[4] = '{3, 4, 5, 7};

  int         m_phase = P_IDLE;
  int         m_credit = 0;
  int         m_quiet = 0;
  logic [1:0] m_disp_id = 2'd0;
  obs_t       m_prev = '0;

  vend_seq_ctrl #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .coin_vld   (coin_vld),
    .coin       (coin),
    .sel_vld    (sel_vld),
    .sel        (sel),
    .cancel     (cancel),
    .disp_req   (disp_req),
    .disp_id    (disp_id),
    .disp_ack   (disp_ack),
    .chg_req    (chg_req),
    .chg_amt    (chg_amt),
    .chg_ack    (chg_ack),
    .credit     (credit),
    .coin_rej   (coin_rej),
    .low_credit (low_credit),
    .vend_done  (vend_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // disp_id / chg_amt only carry meaning while their req is high, so they are masked otherwise.
  function automatic obs_t sample(input bit masked);
    obs_t v;
    v.disp_req   = disp_req;
    v.disp_id    = (masked && !disp_req) ? 2'd0 : disp_id;
    v.chg_req    = chg_req;
    v.chg_amt    = (masked && !chg_req) ? '0 : chg_amt;
    v.credit     = credit;
    v.coin_rej   = coin_rej;
    v.low_credit = low_credit;
    v.vend_done  = vend_done;
    v.busy       = busy;
    return v;
  endfunction

  // Reference model: one call per clock, from the inputs about to be sampled.
  task automatic model_step();
    obs_t o;
    exp_t e;
    int   val;
    bit   fits;
    o   = '0;
    val = (coin == 2'b01) ? 1 : (coin == 2'b10) ? 2 : 0;
    fits = coin_vld && (val > 0) && (m_credit + val <= MAXC);
    o.coin_rej = coin_vld;
    case (m_phase)
      P_IDLE: begin
        o.low_credit = sel_vld;
        if (fits) begin
          m_credit  += val;
          m_phase    = P_CRED;
          m_quiet    = 0;
          o.coin_rej = 1'b0;
        end
      end
      P_CRED: begin
        if (cancel) begin
          m_phase = P_CHG;
        end else if (sel_vld) begin
          if (m_credit >= price[sel]) begin
            m_credit -= price[sel];
            m_disp_id = sel;
            m_phase   = P_DISP;
          end else begin
            o.low_credit = 1'b1;
          end
        end else if (fits) begin
          m_credit  += val;
          m_quiet    = 0;
          o.coin_rej = 1'b0;
        end else begin
          m_quiet++;
          if (m_quiet >= TMO) m_phase = P_CHG;
        end
      end
      P_DISP: begin
        if (disp_ack) begin
          o.vend_done = 1'b1;
          m_phase = (m_credit > 0) ? P_CHG : P_IDLE;
        end
      end
      default: begin
        if (chg_ack) begin
          m_credit = 0;
          m_phase  = P_IDLE;
        end
      end
    endcase
    o.disp_req = (m_phase == P_DISP);
    o.disp_id  = o.disp_req ? m_disp_id : 2'd0;
    o.chg_req  = (m_phase == P_CHG);
    o.chg_amt  = o.chg_req ? CW'(m_credit) : '0;
    o.credit   = CW'(m_credit);
    o.busy     = o.disp_req | o.chg_req;
    if (o != m_prev) begin
      e.cyc = cyc + 1;
      e.o   = o;
      expq.push_back(e);
    end
    m_prev = o;
  endtask

  task automatic step(input int cv, input int c, input int sv, input int s,
                      input int cn, input int da, input int ca);
    @(negedge clk);
    coin_vld = (cv != 0);
    coin     = 2'(c);
    sel_vld  = (sv != 0);
    sel      = 2'(s);
    cancel   = (cn != 0);
    disp_ack = (da != 0);
    chg_ack  = (ca != 0);
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    for (int i = 0; i < 20 && m_phase != P_IDLE; i++)
      step(0, 0, 0, 0, (m_phase == P_CRED) ? 1 : 0, 1, 1);
    idle(1);
  endtask

  task automatic check_zero(input string nm);
    obs_t v;
    v = sample(1'b0);
    n_cmp++;
    if (v !== '0) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", nm, v, obs_t'('0));
    end
  endtask

  // Monitor: whenever the DUT output vector changes, pop and compare the predicted change.
  initial begin
    obs_t v, prev;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      v = sample(1'b1);
      if (!rst) begin
        prev = v;
      end else begin
        while (expq.size() > 0 && expq[0].cyc < cyc) begin
          e = expq.pop_front();
          n_cmp++;
          n_bad++;
          $display("FAIL missed_change cyc=%0d got=%h exp=%h", e.cyc, v, e.o);
        end
        if (v !== prev) begin
          n_cmp++;
          if (expq.size() == 0 || expq[0].cyc != cyc) begin
            n_bad++;
            $display("FAIL unexpected_change cyc=%0d got=%h exp=%h", cyc, v, prev);
          end else begin
            e = expq.pop_front();
            if (v !== e.o) begin
              n_bad++;
              $display("FAIL outputs cyc=%0d got=%h exp=%h", cyc, v, e.o);
            end
          end
        end
        prev = v;
      end
    end
  end

  initial begin
    int cv, c, sv, cn, r;
    bit sparse;
    rst = 1'b1;
    {coin_vld, sel_vld, cancel, disp_ack, chg_ack} = '0;
    coin = 2'd0;
    sel  = 2'd0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_zero("reset_state");
    #1 rst = 1'b1;

    // exact pay
    step(1, 1, 0, 0, 0, 0, 0); step(1, 2, 0, 0, 0, 0, 0); step(0, 0, 1, 0, 0, 0, 0);
    idle(2); step(0, 0, 0, 0, 0, 1, 0); idle(2); settle();
    // overpay with change
    step(1, 2, 0, 0, 0, 0, 0); step(1, 2, 0, 0, 0, 0, 0); step(1, 2, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0); idle(1); step(0, 0, 0, 0, 0, 1, 0); idle(2);
    step(0, 0, 0, 0, 0, 0, 1); idle(2); settle();
    // insufficient credit and invalid coin
    step(1, 2, 0, 0, 0, 0, 0); step(0, 0, 1, 3, 0, 0, 0); step(1, 3, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0); settle();
    // saturation, then coin during dispense
    for (int i = 0; i < 9; i++) step(1, 2, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0); step(1, 2, 0, 0, 0, 0, 0); step(1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 3, 0, 0, 0); step(1, 1, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 1, 0);
    step(1, 2, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0, 1); settle();
    // cancel + sel + coin together
    step(1, 2, 0, 0, 0, 0, 0); step(1, 2, 0, 0, 0, 0, 0); step(1, 1, 1, 0, 1, 0, 0);
    idle(2); step(0, 0, 0, 0, 0, 0, 1); settle();
    // timeout refund
    step(1, 1, 0, 0, 0, 0, 0); idle(TMO + 3); step(0, 0, 0, 0, 0, 0, 1); settle();

    // asynchronous reset in the middle of a dispense
    step(1, 2, 0, 0, 0, 0, 0); step(1, 2, 0, 0, 0, 0, 0); step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    {coin_vld, sel_vld, cancel, disp_ack, chg_ack} = '0;
    #2 rst = 1'b0;
    #1 check_zero("reset_mid_dispense");
    m_phase  = P_IDLE;
    m_credit = 0;
    m_quiet  = 0;
    m_prev   = '0;
    @(negedge clk);
    #2 rst = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      sparse = ((i / 80) % 2) == 1;
      cv = sparse ? int'($urandom_range(0, 19) == 0) : int'($urandom_range(0, 9) < 5);
      r  = int'($urandom_range(0, 7));
      c  = (r == 0) ? 0 : (r < 4) ? 1 : (r < 7) ? 2 : 3;
      sv = sparse ? int'($urandom_range(0, 49) == 0) : int'($urandom_range(0, 19) < 3);
      cn = sparse ? 0 : int'($urandom_range(0, 24) == 0);
      step(cv, c, sv, int'($urandom_range(0, 3)), cn,
           int'($urandom_range(0, 2) == 0), int'($urandom_range(0, 2) == 0));
    end
    settle();

    @(negedge clk);
    @(negedge clk);
    #1;
    while (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL pending_change cyc=%0d got=none exp=%h", e.cyc, e.o);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vend_seq_ctrl.md
Name: vend_seq_ctrl

Overview:
Transaction sequencer for the coin-operated vending datapath. It accepts coin events, accumulates credit in 5-cent units, and checks product selection against per-product prices. It then drives the dispense actuator and change-return unit through req/ack handshakes. It sits between the coin acceptor/keypad front end and the mechanical actuator drivers.

Parameters:
CREDIT_W, 5, width of the credit register in 5c units
MAX_CREDIT, 20, maximum credit held (units); any coin that would exceed it is rejected
PRICE0, 3, price of product 0 (units; 3 = 15c)
PRICE1, 4, price of product 1
PRICE2, 5, price of product 2
PRICE3, 7, price of product 3
TIMEOUT, 1000, idle cycles in CREDIT before automatic refund (>=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; asynchronous assert, active-low (0 = reset)
coin_vld  in  1  one-cycle strobe: a coin is present on coin
coin  in  2  00 none, 01 = 5c (1 unit), 10 = 10c (2 units), 11 = invalid
sel_vld  in  1  one-cycle strobe: a product has been selected
sel  in  2  product index 0..3
cancel  in  1  one-cycle strobe: refund request
disp_req  out  1  dispense request to actuator
disp_id  out  2  product to dispense; stable while disp_req=1
disp_ack  in  1  actuator done; sampled only while disp_req=1
chg_req  out  1  change-return request
chg_amt  out  CREDIT_W  units to return; stable while chg_req=1
chg_ack  in  1  change unit done; sampled only while chg_req=1
credit  out  CREDIT_W  current credit (units)
coin_rej  out  1  one-cycle pulse: last coin was rejected
low_credit  out  1  one-cycle pulse: selection refused for insufficient credit
vend_done  out  1  one-cycle pulse on completed dispense
busy  out  1  1 in DISPENSE or CHANGE

Behaviour:
- All outputs are registered. All outputs reset to 0; state resets to IDLE; timeout counter resets to 0.
- Reset asserted mid-handshake: req outputs drop immediately and credit is lost. This is intentional.
- States: IDLE, CREDIT, DISPENSE, CHANGE (2-bit encoding).
- Coin acceptance: a coin is accepted only in IDLE or CREDIT, only with coin in {01,10}, and only if credit+value <= MAX_CREDIT. Any other coin_vld (including 00 and 11) gives coin_rej=1 in the next cycle with credit unchanged. Rejected coins are returned mechanically and are not part of this block.
- IDLE: credit=0. An accepted coin loads credit and moves to CREDIT. sel_vld in IDLE gives low_credit=1. cancel in IDLE is ignored.
- CREDIT priority within a cycle: cancel > sel_vld > coin_vld. A lower-priority event in the same cycle is dropped; a dropped coin pulses coin_rej.
  - cancel: go to CHANGE.
  - sel_vld with credit >= PRICE[sel]: credit <= credit-PRICE[sel], latch disp_id=sel, go to DISPENSE.
  - sel_vld with credit < PRICE[sel]: pulse low_credit and stay in CREDIT.
  - Accepted coin: add value and clear the timeout counter.
  - Otherwise the counter increments. At count TIMEOUT-1, go to CHANGE.
- DISPENSE: disp_req=1 from the entry cycle. In the cycle disp_ack=1: next cycle disp_req=0 and vend_done=1. Then go to CHANGE if credit>0, else IDLE. All coin_vld are rejected; sel_vld and cancel are ignored.
- CHANGE: chg_amt=credit, chg_req=1. In the cycle chg_ack=1: next cycle chg_req=0, credit=0, state IDLE. Coins are rejected; sel_vld and cancel are ignored.
- Latency: sel_vld to disp_req is 1 cycle. disp_ack to chg_req (when change is due) is 1 cycle.
- Counter wrap: the timeout counter saturates and never wraps. Its width is clog2(TIMEOUT).
- Stray disp_ack/chg_ack outside the matching state are ignored.
- busy=1 exactly when state is DISPENSE or CHANGE.

Decomposition:
- Shared package vend_pkg: state encoding constants (IDLE, CREDIT, DISPENSE, CHANGE), coin code constants (COIN_NONE, COIN_5, COIN_10, COIN_BAD), unit values.
- One natural sub-module, vend_credit_acc: credit register, add/subtract, MAX_CREDIT compare, coin value decode.
- FSM, timeout counter and handshakes stay in vend_seq_ctrl.

Test Plan:
- Exact pay, default params: coins 01,10 (credit=3), then sel_vld sel=0 -> disp_req=1, disp_id=0 next cycle. Ack -> vend_done pulse, state IDLE, no chg_req.
- Overpay: coins 10,10,10 (credit=6), sel=1 -> dispense with credit=2. After disp_ack -> chg_req=1, chg_amt=2. After chg_ack -> credit=0, IDLE.
- Insufficient / invalid: credit=2, sel=3 -> low_credit pulse, credit stays 2. coin=11 -> coin_rej pulse.
- Saturation / busy reject: credit=19, coin 10 -> coin_rej, credit stays 19. Any coin during DISPENSE -> coin_rej.
- Simultaneous events: in CREDIT with credit=4, cancel+sel+coin in the same cycle -> CHANGE with chg_amt=4, coin_rej=1, no disp_req.
- Timeout and reset: TIMEOUT=8, credit=1, no activity -> chg_req exactly 8 cycles after last coin. Assert rst low mid-DISPENSE -> all outputs 0 asynchronously.
